// File: rtl/phy_lane_scheduler_pkg.sv
// Shared constants and state encoding for the PHY lane scheduler.
package phy_lane_scheduler_pkg;

  localparam int LANE_W = 1;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_COM_COUNT = 4;
  localparam logic [7:0] COM_CHAR_DEF = 8'hBC;
  localparam logic [7:0] IDLE_CHAR_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/phy_lane_scheduler_if.sv
// Channel-side and serializer-side signals of the lane scheduler, plus debug taps.
interface phy_lane_scheduler_if
  import phy_lane_scheduler_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
);

  // Handshake: a byte is taken at an edge where valid_in_x=1 and full_x=0; with
  // full_x=1 it is dropped and err_x latches. valid_out qualifies data_out and has
  // no backpressure: the serializer consumes one byte every cycle.
  logic [7:0]              data_in_0;
  logic                    valid_in_0;
  logic [7:0]              data_in_1;
  logic                    valid_in_1;
  logic                    full_0;
  logic                    full_1;
  logic                    err_0;
  logic                    err_1;
  logic [7:0]              data_out;
  logic                    valid_out;
  logic [LANE_W-1:0]       lane_out;
  logic                    active_out;
  state_t                  state_dbg;
  logic [$clog2(DEPTH):0]  count_0;
  logic [$clog2(DEPTH):0]  count_1;

  modport master (
    output data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  full_0, full_1, err_0, err_1, data_out, valid_out, lane_out, active_out,
    input  state_dbg, count_0, count_1
  );

  modport slave (
    input  data_in_0, valid_in_0, data_in_1, valid_in_1,
    output full_0, full_1, err_0, err_1, data_out, valid_out, lane_out, active_out,
    output state_dbg, count_0, count_1
  );

endinterface

// File: rtl/phy_lane_scheduler_lane_fifo.sv
// Per-lane byte FIFO; full/empty derive combinationally from the occupancy count.
module lane_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phy_lane_scheduler.sv
// Two-lane transmit scheduler: COM startup burst, then round-robin byte merge with IDLE fill.
module phy_lane_scheduler
  import phy_lane_scheduler_pkg::*;
#(
  parameter int         DEPTH     = DEF_DEPTH,
  parameter int         COM_COUNT = DEF_COM_COUNT,
  parameter logic [7:0] COM_CHAR  = COM_CHAR_DEF,
  parameter logic [7:0] IDLE_CHAR = IDLE_CHAR_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  phy_lane_scheduler_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(COM_COUNT + 1);

  state_t            state;
  logic [NW-1:0]     com_cnt;
  logic              last_grant;
  logic [7:0]        data_out_r;
  logic              valid_out_r;
  logic [LANE_W-1:0] lane_out_r;
  logic              active_r;
  logic              err_0_r;
  logic              err_1_r;

  logic [7:0]        head_0, head_1;
  logic              full_0, full_1, empty_0, empty_1;
  logic [CW-1:0]     count_0, count_1;
  logic              push_0, push_1, pop_0, pop_1, grant_1, run;

  assign push_0  = bus.valid_in_0 & ~full_0;
  assign push_1  = bus.valid_in_1 & ~full_1;
  assign run     = (state == ST_RUN);
  // last_grant=1 means lane 1 went last, so lane 0 wins the next tie.
  assign grant_1 = ~empty_1 & (empty_0 | ~last_grant);
  assign pop_0   = run & ~empty_0 & ~grant_1;
  assign pop_1   = run & grant_1;

  lane_fifo #(.DEPTH(DEPTH)) u_fifo_0 (
    .clk(clk_2f), .reset(reset), .push(push_0), .din(bus.data_in_0), .pop(pop_0),
    .dout(head_0), .full(full_0), .empty(empty_0), .count(count_0)
  );

  lane_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
    .clk(clk_2f), .reset(reset), .push(push_1), .din(bus.data_in_1), .pop(pop_1),
    .dout(head_1), .full(full_1), .empty(empty_1), .count(count_1)
  );

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state       <= ST_RST;
      com_cnt     <= '0;
      last_grant  <= 1'b1;
      data_out_r  <= 8'h00;
      valid_out_r <= 1'b0;
      lane_out_r  <= '0;
      active_r    <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          state   <= ST_INIT;
          com_cnt <= '0;
        end
        ST_INIT: begin
          data_out_r  <= COM_CHAR;
          valid_out_r <= 1'b0;
          com_cnt     <= com_cnt + 1'b1;
          if (com_cnt == NW'(COM_COUNT - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          active_r <= 1'b1;
          if (pop_0) begin
            data_out_r  <= head_0;
            valid_out_r <= 1'b1;
            lane_out_r  <= '0;
            last_grant  <= 1'b0;
          end else if (pop_1) begin
            data_out_r  <= head_1;
            valid_out_r <= 1'b1;
            lane_out_r  <= LANE_W'(1);
            last_grant  <= 1'b1;
          end else begin
            data_out_r  <= IDLE_CHAR;
            valid_out_r <= 1'b0;
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      err_0_r <= 1'b0;
      err_1_r <= 1'b0;
    end else begin
      if (bus.valid_in_0 & full_0) err_0_r <= 1'b1;
      if (bus.valid_in_1 & full_1) err_1_r <= 1'b1;
    end
  end

  assign bus.full_0     = full_0;
  assign bus.full_1     = full_1;
  assign bus.err_0      = err_0_r;
  assign bus.err_1      = err_1_r;
  assign bus.data_out   = data_out_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.lane_out   = lane_out_r;
  assign bus.active_out = active_r;
  assign bus.state_dbg  = state;
  assign bus.count_0    = count_0;
  assign bus.count_1    = count_1;

endmodule
